// File: rtl/reorder_buffer_if.sv
// Issue/write-back/query/commit bundle between the reorder buffer and the rest of the core.
// master = issue, execution and consumer side; slave = the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int ENTRY_W = 6
);
    logic               alloc_in;
    logic [4:0]         alloc_rd_in;
    logic               alloc_is_store_in;
    logic               alloc_is_branch_in;
    logic [31:0]        alloc_pred_pc_in;
    logic [ENTRY_W-1:0] alloc_entry_out;
    logic               is_full_out;

    logic               alu_broadcast;
    logic [ENTRY_W-1:0] alu_entry;
    logic [31:0]        alu_value;
    logic [31:0]        alu_pc_out;
    logic               lsb_broadcast;
    logic [ENTRY_W-1:0] lsb_entry;
    logic [31:0]        lsb_value;

    logic [ENTRY_W-1:0] qj_in, qk_in;
    logic               qj_ready_out, qk_ready_out;
    logic [31:0]        qj_value_out, qk_value_out;

    logic               commit_valid;
    logic [4:0]         commit_rd;
    logic [31:0]        commit_value;
    logic [ENTRY_W-1:0] commit_entry;
    logic               commit_store;
    logic               roll_back;
    logic [31:0]        roll_back_pc;

    modport master (
        output alloc_in, alloc_rd_in, alloc_is_store_in, alloc_is_branch_in, alloc_pred_pc_in,
        input  alloc_entry_out, is_full_out,
        output alu_broadcast, alu_entry, alu_value, alu_pc_out,
        output lsb_broadcast, lsb_entry, lsb_value,
        output qj_in, qk_in,
        input  qj_ready_out, qk_ready_out, qj_value_out, qk_value_out,
        input  commit_valid, commit_rd, commit_value, commit_entry, commit_store,
        input  roll_back, roll_back_pc
    );

    modport slave (
        input  alloc_in, alloc_rd_in, alloc_is_store_in, alloc_is_branch_in, alloc_pred_pc_in,
        output alloc_entry_out, is_full_out,
        input  alu_broadcast, alu_entry, alu_value, alu_pc_out,
        input  lsb_broadcast, lsb_entry, lsb_value,
        input  qj_in, qk_in,
        output qj_ready_out, qk_ready_out, qj_value_out, qk_value_out,
        output commit_valid, commit_rd, commit_value, commit_entry, commit_store,
        output roll_back, roll_back_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates at tail, captures ALU/LSB results,
// retires one entry per cycle from head and raises roll_back on a branch mispredict.
module reorder_buffer #(
    parameter int ROB_SIZE = 32,
    parameter int ENTRY_W  = 6
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave bus
);
    localparam int                 PTR_W      = $clog2(ROB_SIZE);
    localparam logic [ENTRY_W-1:0] ENTRY_NULL = ENTRY_W'(ROB_SIZE);
    localparam logic [ENTRY_W-1:0] CNT_ONE    = ENTRY_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);

    typedef struct packed {
        logic [4:0]  rd;
        logic        is_store;
        logic        is_branch;
        logic [31:0] pred_pc;
        logic [31:0] real_pc;
        logic [31:0] value;
    } entry_t;

    entry_t [ROB_SIZE-1:0] ent_q, ent_d;
    logic [ROB_SIZE-1:0]   busy_q, busy_d, ready_q, ready_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [ENTRY_W-1:0]    count_q, count_d;

    logic                  commit_valid_q, commit_valid_d, commit_store_q, commit_store_d;
    logic                  roll_back_q, roll_back_d;
    logic [4:0]            commit_rd_q, commit_rd_d;
    logic [31:0]           commit_value_q, commit_value_d, roll_back_pc_q, roll_back_pc_d;
    logic [ENTRY_W-1:0]    commit_entry_q, commit_entry_d;

    logic                  full, alloc_fire, commit_fire, mispredict, alu_hit, lsb_hit;
    logic [PTR_W-1:0]      alu_idx, lsb_idx;
    entry_t                head_ent;

    assign head_ent    = ent_q[head_q];
    assign full        = (count_q == ENTRY_NULL);
    assign alloc_fire  = bus.alloc_in && !full;
    assign commit_fire = (count_q != '0) && ready_q[head_q];
    assign mispredict  = head_ent.is_branch && !head_ent.is_store &&
                         (head_ent.real_pc != head_ent.pred_pc);

    // Broadcasts only land on live entries; stale or null tags fall through.
    assign alu_idx = bus.alu_entry[PTR_W-1:0];
    assign lsb_idx = bus.lsb_entry[PTR_W-1:0];
    assign alu_hit = bus.alu_broadcast && (bus.alu_entry < ENTRY_NULL) && busy_q[alu_idx];
    assign lsb_hit = bus.lsb_broadcast && (bus.lsb_entry < ENTRY_NULL) && busy_q[lsb_idx];

    function automatic logic [32:0] lookup(input logic [ENTRY_W-1:0] tag);
        logic [PTR_W-1:0] idx;
        idx    = tag[PTR_W-1:0];
        lookup = '0;
        if (tag < ENTRY_NULL) begin
            if (bus.alu_broadcast && bus.alu_entry == tag)      lookup = {1'b1, bus.alu_value};
            else if (bus.lsb_broadcast && bus.lsb_entry == tag) lookup = {1'b1, bus.lsb_value};
            else if (busy_q[idx] && ready_q[idx])               lookup = {1'b1, ent_q[idx].value};
        end
    endfunction

    always_comb begin
        {bus.qj_ready_out, bus.qj_value_out} = lookup(bus.qj_in);
        {bus.qk_ready_out, bus.qk_value_out} = lookup(bus.qk_in);
    end

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        ent_d          = ent_q;
        commit_valid_d = 1'b0;
        commit_store_d = 1'b0;
        roll_back_d    = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_entry_d = commit_entry_q;
        roll_back_pc_d = roll_back_pc_q;
        if (rdy_in) begin
            // LSB first so the ALU wins if both name the same entry.
            if (lsb_hit) begin
                ready_d[lsb_idx]       = 1'b1;
                ent_d[lsb_idx].value   = bus.lsb_value;
            end
            if (alu_hit) begin
                ready_d[alu_idx]       = 1'b1;
                ent_d[alu_idx].value   = bus.alu_value;
                ent_d[alu_idx].real_pc = bus.alu_pc_out;
            end
            if (alloc_fire) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = bus.alloc_is_store_in;
                ent_d[tail_q]   = '{rd: bus.alloc_rd_in, is_store: bus.alloc_is_store_in,
                                    is_branch: bus.alloc_is_branch_in,
                                    pred_pc: bus.alloc_pred_pc_in, real_pc: '0, value: '0};
                tail_d          = tail_q + PTR_ONE;
            end
            if (commit_fire) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + PTR_ONE;
                if (head_ent.is_store) begin
                    commit_store_d = 1'b1;
                end else begin
                    commit_valid_d = 1'b1;
                    commit_rd_d    = head_ent.rd;
                    commit_value_d = head_ent.value;
                    commit_entry_d = ENTRY_W'(head_q);
                    if (mispredict) begin
                        roll_back_d    = 1'b1;
                        roll_back_pc_d = head_ent.real_pc;
                    end
                end
            end
            count_d = count_q + (alloc_fire ? CNT_ONE : '0) - (commit_fire ? CNT_ONE : '0);
            // Flush wins over everything else this edge, including a same-cycle alloc.
            if (commit_fire && mispredict) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
                ready_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ent_q          <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_store_q <= 1'b0;
            roll_back_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_entry_q <= '0;
            roll_back_pc_q <= '0;
        end else begin
            ent_q          <= ent_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_store_q <= commit_store_d;
            roll_back_q    <= roll_back_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_entry_q <= commit_entry_d;
            roll_back_pc_q <= roll_back_pc_d;
        end
    end

    assign bus.alloc_entry_out = ENTRY_W'(tail_q);
    assign bus.is_full_out     = full;
    assign bus.commit_valid    = commit_valid_q;
    assign bus.commit_store    = commit_store_q;
    assign bus.roll_back       = roll_back_q;
    assign bus.commit_rd       = commit_rd_q;
    assign bus.commit_value    = commit_value_q;
    assign bus.commit_entry    = commit_entry_q;
    assign bus.roll_back_pc    = roll_back_pc_q;
endmodule
